// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t  : scheduler FSM encoding
//   BYTE_W   : width of one transmitted byte
//   cnt_w()  : counter width helper, never returns less than 1
package uart_tx_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_WAIT = 2'b10,
        ST_GAP  = 2'b11
    } state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick. Scans req starting at index ptr and wraps.
//   req : request vector
//   ptr : index with highest priority this cycle
//   gnt : one-hot winner (0 when no request)
//   idx : encoded winner index
//   any : at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] sel2;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_oh;

    always_comb begin
        // rotate so that req[ptr] lands at bit 0, take the lowest set bit,
        // then rotate the winner back into place
        dbl    = {req, req} >> ptr;
        rot    = dbl[N-1:0];
        rot_oh = rot & (~rot + 1'b1);
        sel2   = {{N{1'b0}}, rot_oh} << ptr;
        gnt    = sel2[N-1:0] | sel2[2*N-1:N];
        any    = |req;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-level UART transmitter among NREQ
// requesters. The grant is held for a whole frame; each byte waits for the
// transmitter's tx_done. Frames are separated by GAP_CYC idle cycles, and a
// frame whose owner holds valid low for STALL_MAX cycles is aborted.
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/data/last : per-requester byte stream (data byte i at [8i+7:8i])
//   req_ready           : byte accepted (only the granted requester, only in LOAD)
//   grant               : one-hot frame owner, 0 when idle
//   tx_data, tx_start   : byte and launch pulse to the transmitter
//   tx_done             : transmitter finished the current byte
//   abort               : one-cycle pulse when a stalled frame is dropped
//
// state | meaning
// IDLE  | arbitrate among valid requesters
// LOAD  | granted requester may hand over its next byte
// WAIT  | byte on the line, waiting for tx_done
// GAP   | forced idle time between frames
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int GAP_CYC   = 16,
    parameter int STALL_MAX = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        grant,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_start,
    input  logic                   tx_done,
    output logic                   abort
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = cnt_w(STALL_MAX);
    localparam int GW = cnt_w(GAP_CYC + 1);
    localparam logic [SW-1:0] STALL_TC = SW'(STALL_MAX - 1);
    localparam logic [GW-1:0] GAP_TC   = GW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                last_q, last_d;
    logic                abort_q, abort_d;
    logic [SW-1:0]       stall_q, stall_d;
    logic [GW-1:0]       gap_q, gap_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic                g_valid;
    logic                g_last;
    logic [BYTE_W-1:0]   g_data;
    logic [IW-1:0]       next_ptr;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // only the owner's lines are ever looked at during a frame
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign next_ptr = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        last_d     = last_q;
        abort_d    = 1'b0;
        stall_d    = stall_q;
        gap_d      = gap_q;
        req_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_gnt;
                    idx_d   = arb_idx;
                    stall_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                req_ready = grant_q & req_valid;
                if (g_valid) begin
                    tx_data_d  = g_data;
                    tx_start_d = 1'b1;
                    last_d     = g_last;
                    stall_d    = '0;
                    state_d    = ST_WAIT;
                end else if (stall_q == STALL_TC) begin
                    abort_d  = 1'b1;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // a done coinciding with our own start cannot belong to this byte
                if (tx_done && !tx_start_q) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        gap_d    = '0;
                        state_d  = ST_GAP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (GAP_CYC == 0 || gap_q == GAP_TC) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
            abort_q    <= 1'b0;
            stall_q    <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            last_q     <= last_d;
            abort_q    <= abort_d;
            stall_q    <= stall_d;
            gap_q      <= gap_d;
        end
    end

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-driven requesters, a fixed-latency
// transmitter model, and a frame-level round-robin reference model.
module tb_uart_tx_sched;

    localparam int NREQ      = 4;
    localparam int GAP_CYC   = 16;
    localparam int STALL_MAX = 8;
    localparam int TX_LAT    = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              abort;
    logic              tx_done;
    logic              tx_done_m = 1'b0;
    logic              tx_done_f = 1'b0;

    assign tx_done = tx_done_m | tx_done_f;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed { logic [7:0] d; logic l; } ent_t;
    typedef struct packed { logic [NREQ-1:0] g; logic [7:0] d; } txe_t;

    ent_t drvq[NREQ][$];
    ent_t mdlq[NREQ][$];
    txe_t log_q[$];
    txe_t exp_q[$];
    int   mdl_ptr = 0;

    logic [NREQ-1:0] xfer_seen = '0;
    bit         tx_busy = 0;
    bit         hold_ok = 0;
    int         tx_cnt = 0;
    logic [7:0] held = '0;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .STALL_MAX(STALL_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .abort     (abort)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        xfer_seen <= req_valid & req_ready;
    end

    // requesters: present the head of each queue, pop after a transfer
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (xfer_seen[i] && drvq[i].size() > 0) drvq[i].delete(0);
            if (drvq[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = drvq[i][0].d;
                req_last[i]         = drvq[i][0].l;
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom_range(0, 1));
            end
        end
    end

    // transmitter model plus per-cycle protocol checks
    always @(negedge clk) begin
        tx_done_m = 1'b0;
        if (reset) begin
            check("ready_in_grant", 32'(req_ready & ~grant), 0);
            check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (tx_start) begin
                check("start_while_busy", 32'(tx_busy), 0);
                log_q.push_back({grant, tx_data});
                held    = tx_data;
                hold_ok = 1;
            end else if (tx_busy && hold_ok) begin
                check("tx_data_hold", 32'(tx_data), 32'(held));
            end
        end else begin
            hold_ok = 0;
        end
        if (tx_busy) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done_m = 1'b1;
                tx_busy   = 0;
                hold_ok   = 0;
            end
        end
        if (reset && tx_start) begin
            tx_busy = 1;
            tx_cnt  = TX_LAT;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        drvq[i].push_back(e);
        mdlq[i].push_back(e);
    endtask

    task automatic add_frame_rand(input int i, input int n);
        for (int k = 0; k < n; k++) add_byte(i, 8'($urandom), k == n - 1);
    endtask

    // whole frames go out in round-robin order of owners starting at mdl_ptr
    task automatic build_expect();
        ent_t e;
        txe_t t;
        int   i;
        bit   found;
        while (1) begin
            found = 0;
            i = 0;
            for (int k = 0; k < NREQ; k++) begin
                i = (mdl_ptr + k) % NREQ;
                if (mdlq[i].size() > 0) begin
                    found = 1;
                    break;
                end
            end
            if (!found) break;
            do begin
                e = mdlq[i].pop_front();
                t.g = '0;
                t.g[i] = 1'b1;
                t.d = e.d;
                exp_q.push_back(t);
            end while (!e.l && mdlq[i].size() > 0);
            mdl_ptr = (i + 1) % NREQ;
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, log_q.size(), n);
    endtask

    task automatic wait_quiet(input string tag);
        int k = 0;
        while ((grant != 0 || tx_busy) && k < 2000) begin
            tick();
            k++;
        end
        check(tag, 32'(grant), 0);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, log_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < log_q.size()) begin
                check({tag, "_grant"}, 32'(log_q[k].g), 32'(exp_q[k].g));
                check({tag, "_data"}, 32'(log_q[k].d), 32'(exp_q[k].d));
            end
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            drvq[i].delete();
            mdlq[i].delete();
        end
        log_q.delete();
        exp_q.delete();
        mdl_ptr = 0;
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_abort", 32'(abort), 0);
    endtask

    task automatic do_reset();
        assert_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic measure_gap(input string tag, input int n0);
        int n = n0;
        while (n < 100) begin
            tick();
            if (grant != 0) break;
            n++;
        end
        check(tag, n, GAP_CYC + 1);
    endtask

    initial begin
        int k;
        int t_done;

        tick();
        do_reset();

        // two-byte frame from requester 0, then gap length before requester 1
        add_byte(0, 8'h55, 1'b0);
        add_byte(0, 8'hAA, 1'b1);
        build_expect();
        wait_log(2, 200, "t1_log");
        compare_log("t1");
        k = 0;
        while (grant != 0 && k < 200) begin
            tick();
            k++;
        end
        check("t1_grant_drop", 32'(grant), 0);
        add_byte(1, 8'h5A, 1'b1);
        measure_gap("t1_gap", 1);
        build_expect();
        wait_log(1, 200, "t1b_log");
        wait_quiet("t1b_quiet");
        compare_log("t1b");

        // competing multi-byte frames; the last two frames show where rr_ptr ended
        do_reset();
        add_frame_rand(0, 3);
        add_frame_rand(2, 3);
        add_frame_rand(0, 1);
        add_frame_rand(3, 1);
        build_expect();
        wait_log(8, 2000, "t2_log");
        wait_quiet("t2_quiet");
        compare_log("t2");

        // two requesters with back-to-back single-byte frames
        do_reset();
        for (int f = 0; f < 4; f++) begin
            add_frame_rand(1, 1);
            add_frame_rand(3, 1);
        end
        build_expect();
        wait_log(8, 2000, "t3_log");
        wait_quiet("t3_quiet");
        compare_log("t3");

        // spurious done in IDLE, stall abort with spurious done in LOAD
        do_reset();
        tx_done_f = 1'b1;
        tick();
        tx_done_f = 1'b0;
        tick();
        check("t4_idle_spur_grant", 32'(grant), 0);
        check("t4_idle_spur_log", log_q.size(), 0);
        add_byte(0, 8'h11, 1'b0);
        add_byte(1, 8'h22, 1'b1);
        wait_log(1, 100, "t4_log1");
        if (log_q.size() > 0) begin
            check("t4_first_grant", 32'(log_q[0].g), 32'h1);
            check("t4_first_data", 32'(log_q[0].d), 32'h11);
        end
        k = 0;
        while (tx_done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("t4_done_seen", 32'(tx_done), 1);
        t_done = cyc;
        tick();
        tick();
        tx_done_f = 1'b1;
        tick();
        tx_done_f = 1'b0;
        k = 0;
        while (abort !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("t4_abort_delay", cyc - t_done, STALL_MAX + 1);
        check("t4_abort_grant", 32'(grant), 0);
        check("t4_no_extra_start", log_q.size(), 1);
        tick();
        check("t4_abort_pulse", 32'(abort), 0);
        measure_gap("t4_gap", 2);
        wait_log(2, 200, "t4_log2");
        if (log_q.size() > 1) begin
            check("t4_next_grant", 32'(log_q[1].g), 32'h2);
            check("t4_next_data", 32'(log_q[1].d), 32'h22);
        end
        wait_quiet("t4_quiet");

        // reset during WAIT of a second byte, late done must be ignored
        do_reset();
        add_byte(2, 8'h6B, 1'b1);
        add_byte(3, 8'h3C, 1'b0);
        add_byte(3, 8'hC3, 1'b1);
        wait_log(3, 500, "t5_log");
        tick();
        tick();
        tick();
        assert_reset();
        tick();
        tick();
        reset = 1'b1;
        k = 0;
        while (tx_busy && k < 100) begin
            tick();
            k++;
        end
        tick();
        tick();
        check("t5_late_grant", 32'(grant), 0);
        check("t5_late_log", log_q.size(), 0);
        add_frame_rand(3, 1);
        add_frame_rand(1, 2);
        build_expect();
        wait_log(3, 500, "t5b_log");
        wait_quiet("t5b_quiet");
        compare_log("t5b");

        // randomized frame mix against the reference model
        do_reset();
        for (int f = 0; f < 16; f++) begin
            add_frame_rand($urandom_range(0, NREQ - 1), $urandom_range(1, 4));
        end
        build_expect();
        wait_log(exp_q.size(), 20000, "t6_log");
        wait_quiet("t6_quiet");
        compare_log("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one byte-level UART transmitter among NREQ requesters.
- Each requester streams a frame of bytes with a valid/ready/last handshake.
- The scheduler locks the grant for a whole frame and feeds bytes to the transmitter one at a time, waiting for each byte's completion.
- It inserts a programmable idle gap between frames and aborts frames whose owner stalls.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYC, 16, idle clk cycles forced between frames (0 allowed).
- STALL_MAX, 1024, clk cycles a granted requester may hold valid low mid-frame before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NREQ  marks final byte of frame; qualified by valid.
- req_ready  out  NREQ  byte accepted this cycle (transfer = valid & ready).
- grant  out  NREQ  one-hot current frame owner; 0 when idle.
- tx_data  out  8  byte to transmitter; held stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse launching a byte.
- tx_done  in  1  one-cycle pulse from transmitter after the stop bit completes.
- abort  out  1  one-cycle pulse when a frame is aborted on stall.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grant=0, req_ready=0, tx_start=0, tx_data=8'h00, abort=0; rr_ptr=0; counters cleared.
- States:
  - IDLE: if any req_valid, pick the first asserted index scanning rr_ptr, rr_ptr+1, ... mod NREQ. Set grant one-hot, go LOAD next cycle. Arbitration takes 1 cycle.
  - LOAD: req_ready[g]=1 combinationally while req_valid[g]=1.
    - On transfer: latch tx_data, tx_start=1 next cycle, remember last, clear the stall counter, go WAIT.
    - If valid is low: increment the stall counter. When it reaches STALL_MAX-1, abort=1, grant=0, go GAP.
  - WAIT: hold tx_data and ignore all req_valid. On tx_done:
    - if the remembered last=1, go GAP and set rr_ptr=(g+1) mod NREQ;
    - else go LOAD.
  - GAP: grant=0. Count GAP_CYC cycles, then go IDLE. If GAP_CYC=0, go directly to IDLE next cycle.
- Only one req_ready bit may be high, and only in LOAD. Non-granted requesters are never readied.
- tx_start never asserts while a byte is outstanding (between tx_start and tx_done).
- A tx_done outside WAIT is ignored.
- A tx_done in the same cycle as tx_start is impossible by contract and is ignored.
- rr_ptr advances on normal completion and on abort (set to g+1 mod NREQ), so a stalled requester loses priority.
- Single-byte frame: the first byte has last=1, giving LOAD, WAIT, GAP.
- Changes to req_valid, req_data or req_last of non-granted requesters during a frame have no effect.
- A req_last seen without a transfer is ignored.
- Reset mid-frame drops everything immediately.
  - A byte already launched completes on the line; its tx_done arrives in IDLE or GAP and is ignored.
- Counter widths: stall counter is $clog2(STALL_MAX) bits; gap counter is $clog2(GAP_CYC+1) bits. Neither wraps; each saturates at its terminal count.
- Throughput: per byte, 1 LOAD cycle + transmitter time. There are no bubbles other than LOAD.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, LOAD=2'b01, WAIT=2'b10, GAP=2'b11;
  - a byte-width constant of 8.
- One sub-module is natural: rr_arbiter. It is a combinational round-robin pick from a request vector and rr_ptr, producing a one-hot grant plus an encoded index. It is reused by other shared-resource controllers.

Test Plan:
- Single requester 0 sends frame 8'h55, 8'hAA (last on AA), tx_done modelled 10 cycles after each tx_start -> tx_start twice with tx_data 55 then AA; grant=0001 throughout; GAP of 16 cycles, then IDLE.
- Requesters 0 and 2 both valid with 3-byte frames, rr_ptr=0 -> frame 0 fully sent, then frame 2; no byte interleaving; rr_ptr ends at 3.
- Requesters 1 and 3 hold valid continuously with 1-byte frames -> grants alternate 1, 3, 1, 3; no starvation over 8 frames.
- Requester 0 sends 1 byte (last=0) then drops valid, STALL_MAX=8 -> abort pulses exactly 8 LOAD cycles after the tx_done; grant=0; requester 1 is granted after the gap.
- Spurious tx_done pulses in IDLE and LOAD -> no state change and no extra tx_start.
- Assert reset low during WAIT of the second byte -> all outputs at reset values asynchronously. After release, the late tx_done is ignored and the next frame starts with arbitration from index 0.
